// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds resolved stores until in-order ROB commit, then drains them to the d-cache.
// Optional store-to-load forwarding ports are enabled by defining STORE_FWD_EN.
module store_commit_buffer #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned TAG_BITS   = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     st_valid,
   input  logic [TAG_BITS-1:0]      st_tag,
   input  logic [ADDR_WIDTH-1:0]    st_addr,
   input  logic [DATA_WIDTH-1:0]    st_data,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     commit_valid,
   input  logic [TAG_BITS-1:0]      commit_tag,
   output logic                     commit_err,
   output logic                     mem_wr_en,
   output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
   output logic [DATA_WIDTH-1:0]    mem_wr_data,
   input  logic                     mem_stall,
   input  logic [ADDR_WIDTH-1:0]    ld_check_addr,
`ifdef STORE_FWD_EN
   output logic                     ld_fwd_valid,
   output logic [DATA_WIDTH-1:0]    ld_fwd_data,
`endif
   output logic                     ld_match
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;

   typedef enum logic [1:0] {StFree, StPending, StCommitted} ent_state_e;

   ent_state_e            state_q [DEPTH];
   ent_state_e            state_d [DEPTH];
   logic [TAG_BITS-1:0]   tag_q   [DEPTH];
   logic [TAG_BITS-1:0]   tag_d   [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_d  [DEPTH];
   logic [DATA_WIDTH-1:0] data_q  [DEPTH];
   logic [DATA_WIDTH-1:0] data_d  [DEPTH];

   logic [PW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
   logic          err_q, err_d;
   logic [IW-1:0] head_idx, cmt_idx, tail_idx;
   logic          alloc, commit_ok, drain;
   logic [DEPTH-1:0] hit;
   logic          unused_ld_bits;

   assign head_idx = head_q[IW-1:0];
   assign cmt_idx  = cmt_q[IW-1:0];
   assign tail_idx = tail_q[IW-1:0];

   assign full  = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
   assign count = tail_q - head_q;

   assign mem_wr_en   = (state_q[head_idx] == StCommitted);
   assign mem_wr_addr = addr_q[head_idx];
   assign mem_wr_data = data_q[head_idx];
   assign commit_err  = err_q;

   // A store allocated this cycle is still FREE in state_q, so it cannot match a commit yet.
   assign alloc     = st_valid && !full && !flush;
   assign commit_ok = commit_valid && (state_q[cmt_idx] == StPending) &&
                      (tag_q[cmt_idx] == commit_tag);
   assign drain     = mem_wr_en && !mem_stall;

   always_comb begin
      head_d  = head_q + PW'(drain);
      cmt_d   = cmt_q + PW'(commit_ok);
      tail_d  = flush ? cmt_d : tail_q + PW'(alloc);
      err_d   = err_q | (commit_valid && !commit_ok) | (st_valid && full && !flush);
      state_d = state_q;
      tag_d   = tag_q;
      addr_d  = addr_q;
      data_d  = data_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (flush && state_q[i] == StPending) begin
            state_d[i] = StFree;
         end
      end
      // Commit is applied after the flush sweep so the retiring store survives.
      if (commit_ok) begin
         state_d[cmt_idx] = StCommitted;
      end
      if (drain) begin
         state_d[head_idx] = StFree;
      end
      if (alloc) begin
         state_d[tail_idx] = StPending;
         tag_d[tail_idx]   = st_tag;
         addr_d[tail_idx]  = st_addr;
         data_d[tail_idx]  = st_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         cmt_q  <= '0;
         tail_q <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= StFree;
            tag_q[i]   <= '0;
            addr_q[i]  <= '0;
            data_q[i]  <= '0;
         end
      end else begin
         head_q  <= head_d;
         cmt_q   <= cmt_d;
         tail_q  <= tail_d;
         err_q   <= err_d;
         state_q <= state_d;
         tag_q   <= tag_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Word-granular alias check; byte offset bits are ignored.
   always_comb begin
      hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit[i] = (state_q[i] != StFree) &&
                  (addr_q[i][ADDR_WIDTH-1:2] == ld_check_addr[ADDR_WIDTH-1:2]);
      end
   end

   assign ld_match       = |hit;
   assign unused_ld_bits = ^ld_check_addr[1:0];

`ifdef STORE_FWD_EN
   logic [IW-1:0] fwd_idx;

   // Live entries are contiguous from head, so scanning oldest-first leaves the youngest hit.
   always_comb begin
      ld_fwd_data = '0;
      fwd_idx     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = head_idx + IW'(k);
         if (hit[fwd_idx]) begin
            ld_fwd_data = data_q[fwd_idx];
         end
      end
   end

   assign ld_fwd_valid = ld_match;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Table-driven bench for store_commit_buffer: each vector drives one cycle and checks the post-edge outputs.
module tb_store_commit_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush, st_valid, commit_valid, mem_stall;
   logic [3:0]  st_tag, commit_tag;
   logic [31:0] st_addr, st_data, ld_check_addr;
   logic        full, commit_err, mem_wr_en, ld_match;
   logic [3:0]  count;
   logic [31:0] mem_wr_addr, mem_wr_data;
`ifdef STORE_FWD_EN
   logic        ld_fwd_valid;
   logic [31:0] ld_fwd_data;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   store_commit_buffer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .st_valid      (st_valid),
      .st_tag        (st_tag),
      .st_addr       (st_addr),
      .st_data       (st_data),
      .full          (full),
      .count         (count),
      .commit_valid  (commit_valid),
      .commit_tag    (commit_tag),
      .commit_err    (commit_err),
      .mem_wr_en     (mem_wr_en),
      .mem_wr_addr   (mem_wr_addr),
      .mem_wr_data   (mem_wr_data),
      .mem_stall     (mem_stall),
      .ld_check_addr (ld_check_addr),
`ifdef STORE_FWD_EN
      .ld_fwd_valid  (ld_fwd_valid),
      .ld_fwd_data   (ld_fwd_data),
`endif
      .ld_match      (ld_match)
   );

   typedef struct {
      logic        st_v;
      logic [3:0]  st_tag;
      logic [31:0] st_addr;
      logic [31:0] st_data;
      logic        cm_v;
      logic [3:0]  cm_tag;
      logic        flush;
      logic        stall;
      logic [31:0] ld_addr;
      logic        e_full;
      logic [3:0]  e_count;
      logic        e_err;
      logic        e_wr;
      logic [31:0] e_addr;
      logic [31:0] e_data;
      logic        e_match;
      logic [31:0] e_fwd;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] sv, input logic [31:0] stag, input logic [31:0] sa,
                      input logic [31:0] sd, input logic [31:0] cv, input logic [31:0] ctag,
                      input logic [31:0] fl, input logic [31:0] stl, input logic [31:0] la,
                      input logic [31:0] ef, input logic [31:0] ec, input logic [31:0] ee,
                      input logic [31:0] ew, input logic [31:0] ea, input logic [31:0] ed,
                      input logic [31:0] em, input logic [31:0] efd);
      vec_t v;
      v.st_v = sv[0];   v.st_tag = stag[3:0]; v.st_addr = sa;   v.st_data = sd;
      v.cm_v = cv[0];   v.cm_tag = ctag[3:0]; v.flush = fl[0]; v.stall = stl[0];
      v.ld_addr = la;   v.e_full = ef[0];    v.e_count = ec[3:0]; v.e_err = ee[0];
      v.e_wr = ew[0];   v.e_addr = ea;       v.e_data = ed;   v.e_match = em[0];
      v.e_fwd = efd;
      vq.push_back(v);
   endtask

   task automatic idle_inputs();
      flush = 0; st_valid = 0; commit_valid = 0; mem_stall = 0;
      st_tag = 0; commit_tag = 0; st_addr = 0; st_data = 0; ld_check_addr = 0;
   endtask

   task automatic run_table(input string name);
      for (int k = 0; k < vq.size(); k++) begin
         @(negedge clk);
         st_valid = vq[k].st_v;  st_tag = vq[k].st_tag; st_addr = vq[k].st_addr;
         st_data = vq[k].st_data; commit_valid = vq[k].cm_v; commit_tag = vq[k].cm_tag;
         flush = vq[k].flush; mem_stall = vq[k].stall; ld_check_addr = vq[k].ld_addr;
         @(posedge clk);
         #1;
         chk($sformatf("%s[%0d].full", name, k), {31'b0, full}, {31'b0, vq[k].e_full});
         chk($sformatf("%s[%0d].count", name, k), {28'b0, count}, {28'b0, vq[k].e_count});
         chk($sformatf("%s[%0d].commit_err", name, k), {31'b0, commit_err}, {31'b0, vq[k].e_err});
         chk($sformatf("%s[%0d].mem_wr_en", name, k), {31'b0, mem_wr_en}, {31'b0, vq[k].e_wr});
         if (vq[k].e_wr) begin
            chk($sformatf("%s[%0d].wr_addr", name, k), mem_wr_addr, vq[k].e_addr);
            chk($sformatf("%s[%0d].wr_data", name, k), mem_wr_data, vq[k].e_data);
         end
         chk($sformatf("%s[%0d].ld_match", name, k), {31'b0, ld_match}, {31'b0, vq[k].e_match});
`ifdef STORE_FWD_EN
         chk($sformatf("%s[%0d].fwd_valid", name, k), {31'b0, ld_fwd_valid},
             {31'b0, vq[k].e_match});
         if (vq[k].e_match) begin
            chk($sformatf("%s[%0d].fwd_data", name, k), ld_fwd_data, vq[k].e_fwd);
         end
`endif
      end
      vq.delete();
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.count", {28'b0, count}, 32'd0);
      chk("reset.full", {31'b0, full}, 32'd0);
      chk("reset.commit_err", {31'b0, commit_err}, 32'd0);
      chk("reset.mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
      chk("reset.mem_wr_addr", mem_wr_addr, 32'd0);
      chk("reset.ld_match", {31'b0, ld_match}, 32'd0);
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      idle_inputs();
      do_reset();

      // Single store: alloc, commit next cycle, write the cycle after.
      add(1, 3, 'h100, 'hDEADBEEF, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0,              1, 3, 0, 0, 0,  0, 1, 0, 1, 'h100, 'hDEADBEEF, 0, 0);
      add(0, 0, 0, 0,              0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      run_table("single");

      // Fill, overflow, then commit and drain; a st_valid while full with a drain is still dropped.
      do_reset();
      for (int i = 0; i < 8; i++)
         add(1, i, 'h1000 + 4 * i, i, 0, 0, 0, 0, 0,  (i == 7), i + 1, 0, 0, 0, 0, 0, 0);
      add(1, 15, 'h2000, 'h5A, 0, 0, 0, 0, 0,  1, 8, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0,          1, 0, 0, 0, 0,  1, 8, 1, 1, 'h1000, 0, 0, 0);
      for (int j = 1; j < 8; j++)
         add((j == 1), 14, 'h3000, 'h99, 1, j, 0, 0, 0,
             0, 8 - j, 1, 1, 'h1000 + 4 * j, j, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0);
      run_table("fill");

      // Stall holds the head write stable; both drain in order on release.
      do_reset();
      add(1, 1, 'h300, 'hA1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 2, 'h304, 'hB2, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0,        1, 1, 0, 1, 0,  0, 2, 0, 1, 'h300, 'hA1, 0, 0);
      add(0, 0, 0, 0,        1, 2, 0, 1, 0,  0, 2, 0, 1, 'h300, 'hA1, 0, 0);
      add(0, 0, 0, 0,        0, 0, 0, 1, 0,  0, 2, 0, 1, 'h300, 'hA1, 0, 0);
      add(0, 0, 0, 0,        0, 0, 0, 1, 0,  0, 2, 0, 1, 'h300, 'hA1, 0, 0);
      add(0, 0, 0, 0,        0, 0, 0, 0, 0,  0, 1, 0, 1, 'h304, 'hB2, 0, 0);
      add(0, 0, 0, 0,        0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      run_table("stall");

      // Flush together with commit 2: store 3 and the same-cycle st_valid vanish without error.
      do_reset();
      add(1, 1, 'h400, 1, 0, 0, 0, 0, 'h408,  0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 2, 'h404, 2, 0, 0, 0, 0, 'h408,  0, 2, 0, 0, 0, 0, 0, 0);
      add(1, 3, 'h408, 3, 1, 1, 0, 0, 'h408,  0, 3, 0, 1, 'h400, 1, 1, 3);
      add(1, 9, 'h500, 9, 1, 2, 1, 0, 'h408,  0, 1, 0, 1, 'h404, 2, 0, 0);
      add(0, 0, 0, 0,     0, 0, 0, 0, 'h408,  0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 7, 'h600, 'h77, 0, 0, 0, 0, 'h408,  0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0,     1, 7, 0, 0, 'h408,  0, 1, 0, 1, 'h600, 'h77, 0, 0);
      add(0, 0, 0, 0,     0, 0, 0, 0, 'h408,  0, 0, 0, 0, 0, 0, 0, 0);
      run_table("flush");

      // Word-granular aliasing and youngest-entry forwarding.
      do_reset();
      add(1, 0, 'h204, 'h11, 0, 0, 0, 0, 'h206,  0, 1, 0, 0, 0, 0, 1, 'h11);
      add(0, 0, 0, 0,        0, 0, 0, 0, 'h208,  0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 'h204, 'h22, 0, 0, 0, 0, 'h204,  0, 2, 0, 0, 0, 0, 1, 'h22);
      add(0, 0, 0, 0,        0, 0, 0, 0, 'h207,  0, 2, 0, 0, 0, 0, 1, 'h22);
      add(0, 0, 0, 0,        0, 0, 0, 0, 'h200,  0, 2, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0,        1, 0, 0, 0, 'h204,  0, 2, 0, 1, 'h204, 'h11, 1, 'h22);
      add(0, 0, 0, 0,        0, 0, 0, 0, 'h204,  0, 1, 0, 0, 0, 0, 1, 'h22);
      run_table("ldmatch");

      // Bad commit tag, then a steady alloc/commit/drain stream across the pointer wrap.
      do_reset();
      add(1, 4, 'h700, 'h44, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0,        1, 5, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0,        1, 4, 0, 0, 0,  0, 1, 1, 1, 'h700, 'h44, 0, 0);
      add(0, 0, 0, 0,        0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++)
         add(1, i % 16, 'h800 + 4 * i, 'hC000 + i, (i >= 1), (i + 15) % 16, 0, 0, 0,
             0, (i == 0) ? 1 : 2, 1, (i >= 1),
             (i >= 1) ? 'h800 + 4 * (i - 1) : 0, (i >= 1) ? 'hC000 + i - 1 : 0, 0, 0);
      add(0, 0, 0, 0, 1, 3, 0, 0, 0,  0, 1, 1, 1, 'h800 + 4 * 19, 'hC000 + 19, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0);
      run_table("wrap");

      // Asynchronous reset while a committed write is stalled at the head.
      do_reset();
      @(negedge clk);
      st_valid = 1; st_tag = 1; st_addr = 'h900; st_data = 'h90;
      @(negedge clk);
      idle_inputs();
      commit_valid = 1; commit_tag = 1; mem_stall = 1;
      @(posedge clk);
      #1;
      chk("midrst.pre_wr_en", {31'b0, mem_wr_en}, 32'd1);
      #2;
      rst_n = 0;
      #1;
      chk("midrst.async_wr_en", {31'b0, mem_wr_en}, 32'd0);
      chk("midrst.async_count", {28'b0, count}, 32'd0);
      @(negedge clk);
      idle_inputs();
      rst_n = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst.after_wr_en", {31'b0, mem_wr_en}, 32'd0);
      chk("midrst.after_count", {28'b0, count}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Sits directly downstream of the memory reservation station.
- Accepts store address/data pairs once their operands resolve and holds them speculatively until the ROB commits each store in order.
- Drains committed stores one per cycle to the d-cache write port.
- Provides a combinational address-match check so the reservation station can hold back loads that alias an in-flight store.

Parameters:
- DEPTH, 8, number of store entries; power of 2, at least 2.
- TAG_BITS, 4, ROB tag width; equals ROB_DEPTH_BITS.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, store data width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  branch mispredict flush; discards uncommitted stores.
- st_valid  in  1  store ready from the reservation station.
- st_tag  in  TAG_BITS  ROB tag of the incoming store.
- st_addr  in  ADDR_WIDTH  store byte address.
- st_data  in  DATA_WIDTH  store data.
- full  out  1  no free entry.
- count  out  $clog2(DEPTH)+1  occupied entries.
- commit_valid  in  1  ROB head is a store retiring this cycle.
- commit_tag  in  TAG_BITS  tag of the retiring store.
- commit_err  out  1  sticky; set on a bad commit or an overflow.
- mem_wr_en  out  1  write request to the d-cache.
- mem_wr_addr  out  ADDR_WIDTH  write address.
- mem_wr_data  out  DATA_WIDTH  write data.
- mem_stall  in  1  d-cache not accepting writes this cycle.
- ld_check_addr  in  ADDR_WIDTH  load address to check.
- ld_match  out  1  an in-flight store aliases ld_check_addr.

Behaviour:
- Storage
  - Circular buffer with pointers head, cmt and tail, each $clog2(DEPTH)+1 bits including a wrap bit.
  - Entry state is FREE, PENDING or COMMITTED.
  - head..cmt-1 are COMMITTED, cmt..tail-1 are PENDING.
  - full = (low bits equal) and (wrap bits differ); count = tail - head.
- Reset (async, rst_n=0)
  - All entries FREE; all pointers 0; all outputs 0.
  - commit_err cleared only by reset.
  - Reset mid-drain abandons the write in progress.
- Allocate
  - On st_valid and !full: write entry[tail] as PENDING and increment tail. Visible to ld_match and count the next cycle.
  - st_valid while full: store dropped, commit_err set.
- Commit
  - On commit_valid, entry[cmt] must be PENDING with tag == commit_tag. If so it becomes COMMITTED and cmt increments.
  - Otherwise: no state change, commit_err set.
  - At most one commit per cycle.
  - A store allocated in the same cycle cannot be committed in that cycle.
- Drain
  - mem_wr_en = entry[head] COMMITTED.
  - mem_wr_addr/mem_wr_data = entry[head] fields; outputs are driven purely from registers.
  - Write is accepted at a clock edge where mem_wr_en=1 and mem_stall=0: entry[head] becomes FREE and head increments.
  - While mem_stall=1, outputs are held stable.
  - A store can be written, at the earliest, the cycle after its commit.
- Flush
  - Every PENDING entry becomes FREE and tail <= cmt, using cmt after any same-cycle commit.
  - A commit in the flush cycle is applied first, so that store survives.
  - st_valid in the flush cycle is dropped silently, with no error.
  - COMMITTED entries keep draining through the flush.
- Simultaneous events
  - Allocate, commit and drain may all occur in one cycle.
  - When full, a drain in the same cycle does not free a slot for a same-cycle st_valid: full is evaluated before the edge.
- ld_match
  - Combinational.
  - 1 if any non-FREE entry has addr[ADDR_WIDTH-1:2] == ld_check_addr[ADDR_WIDTH-1:2] (word compare).
- Wrap-around
  - Pointers wrap modulo 2*DEPTH; entry index = low bits.

Optional Feature:
- Macro: STORE_FWD_EN.
- Enabled:
  - Adds outputs ld_fwd_valid (1) and ld_fwd_data (DATA_WIDTH).
  - ld_fwd_valid = ld_match; ld_fwd_data = data of the youngest matching non-FREE entry, i.e. the one closest to tail.
  - Allows the load to bypass the d-cache.
- Disabled: ports absent; loads with ld_match=1 must wait for the drain.

Test Plan:
- Reset then one store: st tag=3, addr=0x100, data=0xDEADBEEF; commit tag=3 next cycle -> mem_wr_en=1 one cycle later with 0x100/0xDEADBEEF; count returns 0 after acceptance.
- Fill 8 stores, then a 9th st_valid -> full=1, 9th dropped, commit_err=1, count=8.
- Commit two stores, then hold mem_stall=1 for 3 cycles -> mem_wr_* stable at the first store; both writes issue in order on release.
- Allocate tags 1,2,3; commit 1; flush in the same cycle as commit 2 -> stores 1,2 drain and store 3 is discarded; tail==cmt after flush.
- Store at 0x204 pending; ld_check_addr=0x206 -> ld_match=1; with ld_check_addr=0x208 -> ld_match=0; with STORE_FWD_EN and two stores to 0x204 (data 0x11 then 0x22) -> ld_fwd_data=0x22.
- Commit with tag 5 when entry[cmt] has tag 4 -> no state change, commit_err=1; run 20 alloc/commit/drain cycles across the pointer wrap -> data order preserved.
